inert_cmd_seq: RTL and testbench

Command sequencer that sits directly upstream of the 16-bit SPI master and drives the inertial sensor. After a power-up delay it sends four configuration writes. It then waits on the sensor data-ready interrupt and runs read transactions for each sample. It assembles 16-bit yaw (and optionally pitch) results and presents them to the downstream control logic with a one-cycle valid strobe.

---
 rtl/inert_cmd_seq.sv | 185 ++++++++++++++++++
 tb/tb_inert_cmd_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/inert_cmd_seq.sv
// Inertial-sensor command sequencer: power-up delay, four config writes, then INT-driven yaw reads.
// Define PITCH_RD_EN to extend each read sequence with the pitch bytes and drive the pitch output.
module inert_cmd_seq #(
  parameter int PWR_UP_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] yaw,
  output logic [15:0] pitch,
  output logic        vld,
  output logic        init_done
);

  // state     | meaning
  // PWRUP     | power-up delay counting
  // SEND      | wrt pulse, cmd holds ROM[idx]
  // WAIT_DONE | waiting for a fresh done rise
  // WAIT_INT  | idle, sampling synchronized INT
  // UPDATE    | yaw/pitch just loaded, vld pulse
  typedef enum logic [2:0] {PWRUP, SEND, WAIT_DONE, WAIT_INT, UPDATE} state_t;

`ifdef PITCH_RD_EN
  localparam logic [2:0] LAST_IDX = 3'd7;
`else
  localparam logic [2:0] LAST_IDX = 3'd5;
`endif

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_idx, w_idx_nxt;
  logic [PWR_UP_W-1:0] r_cnt;
  logic                r_int_meta, r_int_s, r_done_q;
  logic                w_done_rise, w_init_set;
  logic                r_wrt, r_vld, r_init_done;
  logic [15:0]         r_cmd, r_yaw;
  logic [7:0]          r_yl;
  logic                w_unused_rd;

  function automatic logic [15:0] rom(input logic [2:0] i);
    case (i)
      3'd0:    rom = 16'h0D02;
      3'd1:    rom = 16'h1160;
      3'd2:    rom = 16'h1560;
      3'd3:    rom = 16'h1460;
      3'd4:    rom = 16'hA600;
      3'd5:    rom = 16'hA700;
      3'd6:    rom = 16'hA200;
      default: rom = 16'hA300;
    endcase
  endfunction

  assign w_done_rise = done & ~r_done_q;
  assign w_unused_rd = ^rd_data[15:8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_int_meta <= 1'b0;
      r_int_s    <= 1'b0;
      r_done_q   <= 1'b0;
    end else begin
      r_int_meta <= INT;
      r_int_s    <= r_int_meta;
      r_done_q   <= done;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_init_set  = 1'b0;
    case (r_state)
      PWRUP: begin
        if (&r_cnt) begin
          w_state_nxt = SEND;
          w_idx_nxt   = 3'd0;
        end
      end
      SEND: w_state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (w_done_rise) begin
          if (r_idx == 3'd3) begin
            w_init_set  = 1'b1;
            w_state_nxt = WAIT_INT;
          end else if (r_idx == LAST_IDX) begin
            w_state_nxt = UPDATE;
          end else begin
            w_idx_nxt   = r_idx + 3'd1;
            w_state_nxt = SEND;
          end
        end
      end
      WAIT_INT: begin
        if (r_int_s) begin
          w_idx_nxt   = 3'd4;
          w_state_nxt = SEND;
        end
      end
      UPDATE:  w_state_nxt = WAIT_INT;
      default: w_state_nxt = PWRUP;
    endcase
  end

  // wrt/cmd/vld are registered off the next state so they line up with SEND/UPDATE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= PWRUP;
      r_idx       <= 3'd0;
      r_cnt       <= '0;
      r_wrt       <= 1'b0;
      r_vld       <= 1'b0;
      r_cmd       <= 16'h0000;
      r_init_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_wrt   <= (w_state_nxt == SEND);
      r_vld   <= (w_state_nxt == UPDATE);
      if (r_state == PWRUP) r_cnt <= r_cnt + PWR_UP_W'(1);
      if (w_state_nxt == SEND) r_cmd <= rom(w_idx_nxt);
      if (w_init_set) r_init_done <= 1'b1;
    end
  end

`ifdef PITCH_RD_EN
  logic [7:0]  r_yh, r_pl;
  logic [15:0] r_pitch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_yl <= 8'h00;
      r_yh <= 8'h00;
      r_pl <= 8'h00;
    end else if (r_state == WAIT_DONE && w_done_rise) begin
      case (r_idx)
        3'd4:    r_yl <= rd_data[7:0];
        3'd5:    r_yh <= rd_data[7:0];
        3'd6:    r_pl <= rd_data[7:0];
        default: ;
      endcase
    end
  end

  // The final byte is taken straight from rd_data so results are valid in the vld cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_yaw   <= 16'h0000;
      r_pitch <= 16'h0000;
    end else if (w_state_nxt == UPDATE) begin
      r_yaw   <= {r_yh, r_yl};
      r_pitch <= {rd_data[7:0], r_pl};
    end
  end

  assign pitch = r_pitch;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_yl <= 8'h00;
    end else if (r_state == WAIT_DONE && w_done_rise && r_idx == 3'd4) begin
      r_yl <= rd_data[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_yaw <= 16'h0000;
    end else if (w_state_nxt == UPDATE) begin
      r_yaw <= {rd_data[7:0], r_yl};
    end
  end

  assign pitch = 16'h0000;
`endif

  assign wrt       = r_wrt;
  assign cmd       = r_cmd;
  assign yaw       = r_yaw;
  assign vld       = r_vld;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_inert_cmd_seq.sv
// Randomized bench for inert_cmd_seq: SPI responder with random latency/bytes, command-list reference model.
module tb_inert_cmd_seq;
  localparam int PW = 4;
`ifdef PITCH_RD_EN
  localparam int LAST = 7;
`else
  localparam int LAST = 5;
`endif

  logic        clk = 1'b0;
  logic        rst, INT, done;
  logic [15:0] rd_data;
  logic        wrt, vld, init_done;
  logic [15:0] cmd, yaw, pitch;

  always #5 clk = ~clk;

  inert_cmd_seq #(.PWR_UP_W(PW)) dut (
    .clk(clk), .rst(rst), .INT(INT), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .yaw(yaw), .pitch(pitch), .vld(vld), .init_done(init_done)
  );

  int n_tests = 0, n_fail = 0;
  int cyc = 0, pend_wrt = -1, exp_vld = -1, exp_init = -1, idle_from = 0;
  int k = 0, cur = 0, pend_clear = 0, lat_left = 0, vld_count = 0;
  bit mdl_idle = 0, s_prev = 0, prev_vld = 0, in_yh = 0, rise = 0;
  logic [7:0]  got [8];
  logic [7:0]  rb;
  logic [15:0] mdl_yaw = 16'h0, mdl_pitch = 16'h0, ey, ep;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // The command list: four config writes, then the read list up to LAST.
  function automatic logic [15:0] exp_cmd(input int i);
    case (i)
      0: return 16'h0D02;
      1: return 16'h1160;
      2: return 16'h1560;
      3: return 16'h1460;
      4: return 16'hA600;
      5: return 16'hA700;
      6: return 16'hA200;
      default: return 16'hA300;
    endcase
  endfunction

  // Reference model and SPI responder, evaluated 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!rst) begin
        if (wrt || cyc == pend_wrt) chk("wrt_cycle", 32'(wrt), 32'(cyc == pend_wrt));
        if (cyc == pend_wrt) pend_wrt = -1;
        if (wrt) begin
          chk("cmd", 32'(cmd), 32'(exp_cmd(k)));
          chk("init_at_wrt", 32'(init_done), 32'(k >= 4));
          chk("yaw_hold", 32'(yaw), 32'(mdl_yaw));
          cur = k;
        end
        if (vld || cyc == exp_vld) chk("vld_cycle", 32'(vld), 32'(cyc == exp_vld));
        if (vld) begin
          ey = {got[5], got[4]};
`ifdef PITCH_RD_EN
          ep = {got[7], got[6]};
`else
          ep = 16'h0000;
`endif
          chk("yaw", 32'(yaw), 32'(ey));
          chk("pitch", 32'(pitch), 32'(ep));
          chk("vld_b2b", 32'(prev_vld), 32'd0);
          mdl_yaw = ey;
          mdl_pitch = ep;
          vld_count++;
        end
        if (cyc == exp_vld) exp_vld = -1;
        if (cyc == exp_init) begin
          chk("init_done", 32'(init_done), 32'd1);
          exp_init = -1;
        end
        // INT seen at edge c-1 is visible to the idle state at cycle c
        if (mdl_idle && cyc >= idle_from && s_prev) begin
          pend_wrt = cyc + 1;
          mdl_idle = 0;
        end
        prev_vld = vld;

        rise = 0;
        if (pend_clear > 0) begin
          pend_clear--;
          if (pend_clear == 0) done = 1'b0;
        end
        if (lat_left > 0) begin
          lat_left--;
          if (lat_left == 0) rise = 1;
        end
        if (rise) begin
          rb = 8'($urandom);
          done = 1'b1;
          rd_data = {8'($urandom), rb};
          got[cur] = rb;
          chk("cmd_stable", 32'(cmd), 32'(exp_cmd(cur)));
          in_yh = 0;
          if (cur == 3) begin
            mdl_idle = 1; idle_from = cyc + 1; exp_init = cyc + 1; k = 4;
          end else if (cur == LAST) begin
            exp_vld = cyc + 1; mdl_idle = 1; idle_from = cyc + 2; k = 4;
          end else begin
            k = cur + 1; pend_wrt = cyc + 1;
          end
        end else begin
          rd_data = 16'($urandom);
        end

        if (wrt) begin
          pend_clear = ($urandom_range(0, 2) == 0) ? 2 : 1;
          lat_left = (cur < 4) ? 20 : int'($urandom_range(3, 12));
          if (exp_cmd(cur) == 16'hA700) in_yh = 1;
        end
      end
      s_prev = INT;
    end
  end

  task automatic mdl_reset();
    done = 1'b0; pend_wrt = -1; exp_vld = -1; exp_init = -1; mdl_idle = 0;
    k = 0; cur = 0; pend_clear = 0; lat_left = 0; in_yh = 0; prev_vld = 0;
    mdl_yaw = 16'h0; mdl_pitch = 16'h0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    pend_wrt = cyc + (1 << PW);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_wrt"}, 32'(wrt), 32'd0);
    chk({pfx, "_cmd"}, 32'(cmd), 32'd0);
    chk({pfx, "_yaw"}, 32'(yaw), 32'd0);
    chk({pfx, "_pitch"}, 32'(pitch), 32'd0);
    chk({pfx, "_vld"}, 32'(vld), 32'd0);
    chk({pfx, "_init"}, 32'(init_done), 32'd0);
  endtask

  task automatic wait_init(input int limit);
    int n = 0;
    while (!(mdl_idle && k == 4) && n < limit) begin @(negedge clk); n++; end
    if (n >= limit) chk("tmo_init", 32'd0, 32'd1);
  endtask

  task automatic wait_vld(input int target, input int limit);
    int n = 0;
    while (vld_count < target && n < limit) begin @(negedge clk); n++; end
    if (n >= limit) chk("tmo_vld", 32'(vld_count), 32'(target));
  endtask

  task automatic wait_quiet(input int limit);
    int n = 0;
    while (!(mdl_idle && lat_left == 0 && pend_wrt < 0 && exp_vld < 0) && n < limit) begin
      @(negedge clk); n++;
    end
    if (n >= limit) chk("tmo_quiet", 32'd0, 32'd1);
  endtask

  task automatic pulse_int(input int n);
    @(negedge clk);
    INT = 1'b1;
    repeat (n) @(negedge clk);
    INT = 1'b0;
  endtask

  initial begin
    int tgt, n;
    rst = 1'b1; INT = 1'b0; done = 1'b0; rd_data = 16'h0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    release_rst();
    wait_init(300);

    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(1, 6)) @(negedge clk);
      tgt = vld_count + 1;
      pulse_int($urandom_range(1, 3));
      wait_vld(tgt, 300);
      wait_quiet(100);
    end

    @(negedge clk);
    INT = 1'b1;
    wait_vld(vld_count + 4, 800);
    INT = 1'b0;
    wait_quiet(200);
    repeat (3) @(negedge clk);
    wait_quiet(200);

    pulse_int(2);
    n = 0;
    while (!in_yh && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("tmo_yh", 32'd0, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    mdl_reset();
    repeat (2) @(negedge clk);
    release_rst();
    wait_init(300);
    tgt = vld_count + 1;
    pulse_int(1);
    wait_vld(tgt, 300);
    wait_quiet(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
